// File: rtl/bist_sequencer_if.sv
// rtl/bist_sequencer_if.sv - BIST sequencer request/response and datapath control bundle
// The controller side uses the slave modport; the requester drives start and the CUT response.
interface bist_sequencer_if #(
  parameter int MISR_W = 16
);
  logic              bist_start;
  logic              resp_in;
  logic              lfsr_reset;
  logic              lfsr_7b_en;
  logic              lfsr_9b_en;
  logic              test_mode;
  logic              busy;
  logic [MISR_W-1:0] signature;
  logic              bist_end;
  logic              pass_nfail;

  modport master (
    output bist_start, resp_in,
    input  lfsr_reset, lfsr_7b_en, lfsr_9b_en, test_mode, busy, signature, bist_end, pass_nfail
  );

  modport slave (
    input  bist_start, resp_in,
    output lfsr_reset, lfsr_7b_en, lfsr_9b_en, test_mode, busy, signature, bist_end, pass_nfail
  );
endinterface

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - BIST controller: seeds/steps the LFSRs, compacts the CUT response, checks the signature
// Every output is a register or a state decode, so nothing combinational reaches the pins from the inputs.
module bist_sequencer #(
  parameter int                N_PATTERNS  = 100,
  parameter int                CUT_LATENCY = 2,
  parameter int                MISR_W      = 16,
  parameter logic [MISR_W-1:0] MISR_POLY   = 16'h8016,
  parameter logic [MISR_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bist_sequencer_if.slave bus
);

  localparam int CNT_MAX = (N_PATTERNS > CUT_LATENCY) ? N_PATTERNS : CUT_LATENCY;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int FL_LAST = (CUT_LATENCY > 0) ? CUT_LATENCY - 1 : 0;

  localparam logic [CW-1:0] RUN_LAST_C   = CW'(N_PATTERNS - 1);
  localparam logic [CW-1:0] FLUSH_LAST_C = CW'(FL_LAST);

  typedef enum logic [2:0] {
    IDLE, SEED, RUN, FLUSH, COMPARE, DONE
  } state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic              bist_end_q, bist_end_d;
  logic              pass_q, pass_d;

  logic              start_edge;
  logic              capture;
  logic [MISR_W-1:0] misr_next;

  assign start_edge = bus.bist_start & ~start_q;

  always_comb begin
    misr_next    = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0);
    misr_next[0] = misr_next[0] ^ bus.resp_in;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misr_d     = misr_q;
    bist_end_d = bist_end_q;
    pass_d     = pass_q;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = SEED;
      end
      SEED: begin
        cnt_d   = '0;
        misr_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        capture = 1'b1;
        if (cnt_q == RUN_LAST_C) begin
          // The counter is cleared here so FLUSH can reuse it.
          cnt_d   = '0;
          state_d = (CUT_LATENCY == 0) ? COMPARE : FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        capture = 1'b1;
        if (cnt_q == FLUSH_LAST_C) begin
          cnt_d   = '0;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPARE: begin
        pass_d     = (misr_q == GOLDEN_SIG);
        bist_end_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (start_edge) begin
          bist_end_d = 1'b0;
          pass_d     = 1'b0;
          state_d    = SEED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) misr_d = misr_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      // Reset high so a request already asserted through reset is not taken as an edge.
      start_q    <= 1'b1;
      cnt_q      <= '0;
      misr_q     <= '0;
      bist_end_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.bist_start;
      cnt_q      <= cnt_d;
      misr_q     <= misr_d;
      bist_end_q <= bist_end_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.lfsr_reset = (state_q == SEED);
  assign bus.lfsr_7b_en = (state_q == RUN);
  assign bus.lfsr_9b_en = (state_q == RUN);
  assign bus.test_mode  = (state_q == SEED) || (state_q == RUN) || (state_q == FLUSH);
  assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
  assign bus.signature  = misr_q;
  assign bus.bist_end   = bist_end_q;
  assign bus.pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - self-checking bench for bist_sequencer (two configurations)
// A cycle-position model predicts every output; directed literals pin the model.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic run_chk = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bist_sequencer_if #(.MISR_W(8)) ia ();
  bist_sequencer_if #(.MISR_W(8)) ib ();

  bist_sequencer #(
    .N_PATTERNS(4), .CUT_LATENCY(1), .MISR_W(8), .MISR_POLY(8'h1D), .GOLDEN_SIG(8'h1F)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ia.slave)
  );

  bist_sequencer #(
    .N_PATTERNS(1), .CUT_LATENCY(0), .MISR_W(8), .MISR_POLY(8'h1D), .GOLDEN_SIG(8'h01)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ib.slave)
  );

  // t = edges since the accepted start edge; act = a run has been accepted since reset.
  typedef struct packed {
    bit       act;
    int       t;
    bit       sq;
    bit [7:0] sig;
    bit       pass;
  } model_t;

  model_t ma, mb;

  function automatic bit [7:0] misr(input bit [7:0] m, input bit r, input bit [7:0] poly);
    bit [7:0] n;
    n    = (m << 1) ^ (m[7] ? poly : 8'h00);
    n[0] = n[0] ^ r;
    return n;
  endfunction

  function automatic model_t step(input model_t m, input bit rstn, input bit start, input bit resp,
                                  input int n, input int l, input bit [7:0] poly, input bit [7:0] gold);
    model_t r;
    bit     st_edge;
    r = m;
    if (!rstn) begin
      r.act = 1'b0; r.t = 0; r.sq = 1'b1; r.sig = 8'h00; r.pass = 1'b0;
      return r;
    end
    st_edge = start && !m.sq;
    r.sq    = start;
    if (!m.act) begin
      if (st_edge) begin r.act = 1'b1; r.t = 0; end
    end else if (m.t >= n + l + 2) begin
      if (st_edge) begin r.t = 0; r.pass = 1'b0; end
    end else begin
      if (m.t == 0) r.sig = 8'h00;
      else if (m.t <= n + l) r.sig = misr(m.sig, resp, poly);
      if (m.t == n + l + 1) r.pass = (m.sig == gold);
      r.t = m.t + 1;
    end
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input model_t m, input int n, input int l,
                     input logic lr, input logic e7, input logic e9, input logic tm, input logic bsy,
                     input logic [7:0] sig, input logic be, input logic pn);
    bit done;
    done = m.act && (m.t >= n + l + 2);
    chk1({tag, ".lfsr_reset"}, lr,  m.act && (m.t == 0));
    chk1({tag, ".lfsr_7b_en"}, e7,  m.act && (m.t >= 1) && (m.t <= n));
    chk1({tag, ".lfsr_9b_en"}, e9,  m.act && (m.t >= 1) && (m.t <= n));
    chk1({tag, ".test_mode"},  tm,  m.act && (m.t <= n + l));
    chk1({tag, ".busy"},       bsy, m.act && (m.t <= n + l + 1));
    chk8({tag, ".signature"},  sig, m.sig);
    chk1({tag, ".bist_end"},   be,  done);
    chk1({tag, ".pass_nfail"}, pn,  done && m.pass);
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst_n, ia.bist_start, ia.resp_in, 4, 1, 8'h1D, 8'h1F);
    mb = step(mb, rst_n, ib.bist_start, ib.resp_in, 1, 0, 8'h1D, 8'h01);
  end

  always @(negedge clk) begin
    if (run_chk) begin
      cmp("A", ma, 4, 1, ia.lfsr_reset, ia.lfsr_7b_en, ia.lfsr_9b_en, ia.test_mode, ia.busy,
          ia.signature, ia.bist_end, ia.pass_nfail);
      cmp("B", mb, 1, 0, ib.lfsr_reset, ib.lfsr_7b_en, ib.lfsr_9b_en, ib.test_mode, ib.busy,
          ib.signature, ib.bist_end, ib.pass_nfail);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic start_a();
    ia.bist_start = 1'b1;
    tick(1);
    ia.bist_start = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_sig [5];
    logic [7:0] pat;
    exp_sig[0] = 8'h01; exp_sig[1] = 8'h03; exp_sig[2] = 8'h07;
    exp_sig[3] = 8'h0F; exp_sig[4] = 8'h1F;
    pat = 8'b1011_0010;

    ma = '0; ma.sq = 1'b1;
    mb = '0; mb.sq = 1'b1;
    rst_n = 1'b0;
    ia.bist_start = 1'b1; ib.bist_start = 1'b1;
    ia.resp_in = 1'b0;    ib.resp_in = 1'b0;

    // Reset with the request held high; release must not start a run.
    tick(1);
    run_chk = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk1("idle_busy", ia.busy, 1'b0);
    chk8("idle_sig", ia.signature, 8'h00);
    chk1("idle_end", ia.bist_end, 1'b0);
    chk1("idle_seed", ia.lfsr_reset, 1'b0);
    ia.bist_start = 1'b0; ib.bist_start = 1'b0;
    tick(1);

    // Pass path, with a second edge during RUN that must be ignored.
    ia.resp_in = 1'b1;
    start_a();
    chk1("pass_seed", ia.lfsr_reset, 1'b1);
    chk1("pass_seed_en", ia.lfsr_7b_en, 1'b0);
    tick(1);
    chk1("pass_run_en", ia.lfsr_9b_en, 1'b1);
    chk8("pass_run_sig0", ia.signature, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk8("pass_sig_seq", ia.signature, exp_sig[i]);
      if (i == 0) ia.bist_start = 1'b1;
      if (i == 1) ia.bist_start = 1'b0;
      if (i == 2) chk1("pass_last_run_en", ia.lfsr_7b_en, 1'b1);
      if (i == 3) chk1("pass_flush_en", ia.lfsr_7b_en, 1'b0);
    end
    chk1("pass_compare_end", ia.bist_end, 1'b0);
    chk1("pass_compare_busy", ia.busy, 1'b1);
    tick(1);
    chk1("pass_end", ia.bist_end, 1'b1);
    chk1("pass_ok", ia.pass_nfail, 1'b1);
    chk1("pass_busy_low", ia.busy, 1'b0);

    // Fail path, restarted from DONE.
    tick(2);
    chk1("done_hold", ia.bist_end, 1'b1);
    ia.resp_in = 1'b0;
    start_a();
    chk1("restart_seed", ia.lfsr_reset, 1'b1);
    chk1("restart_end_clr", ia.bist_end, 1'b0);
    tick(7);
    chk8("fail_sig", ia.signature, 8'h00);
    chk1("fail_end", ia.bist_end, 1'b1);
    chk1("fail_pn", ia.pass_nfail, 1'b0);

    // Reset in the middle of RUN, then a clean run.
    ia.resp_in = 1'b1;
    start_a();
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk1("midrst_en", ia.lfsr_7b_en, 1'b0);
    chk8("midrst_sig", ia.signature, 8'h00);
    chk1("midrst_busy", ia.busy, 1'b0);
    rst_n = 1'b1;
    tick(2);
    start_a();
    tick(7);
    chk8("rerun_sig", ia.signature, 8'h1F);
    chk1("rerun_end", ia.bist_end, 1'b1);
    chk1("rerun_pn", ia.pass_nfail, 1'b1);

    // Patterned response, checked cycle by cycle against the model.
    start_a();
    for (int i = 0; i < 8; i++) begin
      ia.resp_in = pat[i];
      tick(1);
    end
    tick(2);

    // Minimal configuration: one pattern, no flush.
    ib.resp_in = 1'b1;
    ib.bist_start = 1'b1;
    tick(1);
    ib.bist_start = 1'b0;
    chk1("b_seed", ib.lfsr_reset, 1'b1);
    tick(1);
    chk1("b_run_en", ib.lfsr_7b_en, 1'b1);
    chk8("b_run_sig", ib.signature, 8'h00);
    tick(1);
    chk1("b_cmp_en", ib.lfsr_7b_en, 1'b0);
    chk8("b_cmp_sig", ib.signature, 8'h01);
    chk1("b_cmp_end", ib.bist_end, 1'b0);
    tick(1);
    chk1("b_end", ib.bist_end, 1'b1);
    chk1("b_pn", ib.pass_nfail, 1'b1);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
